// File: rtl/fetch_receiver_if.sv
// Bundle between the instruction-buffer front-end, the fetch receiver and decode.
// The receiver issues get_data_req, so it takes the master modport; the front-end/decode side takes slave.
interface fetch_receiver_if;
    logic        get_data_req;
    logic [1:0]  fb_valid;
    logic [31:0] fb_pc_out1;
    logic [31:0] fb_pc_out2;
    logic [31:0] fb_inst_out1;
    logic [31:0] fb_inst_out2;
    logic        fb_pred_taken1;
    logic        fb_pred_taken2;
    logic [31:0] fb_pre_branch_addr1;
    logic [31:0] fb_pre_branch_addr2;
    logic [1:0]  fb_is_exception1;
    logic [1:0]  fb_is_exception2;
    logic [6:0]  fb_pc_exception_cause1;
    logic [6:0]  fb_pc_exception_cause2;
    logic [6:0]  fb_instbuffer_exception_cause1;
    logic [6:0]  fb_instbuffer_exception_cause2;

    logic [1:0]  dec_valid;
    logic [31:0] dec_pc1;
    logic [31:0] dec_pc2;
    logic [31:0] dec_inst1;
    logic [31:0] dec_inst2;
    logic        dec_pred_taken1;
    logic        dec_pred_taken2;
    logic [31:0] dec_pred_addr1;
    logic [31:0] dec_pred_addr2;
    logic        dec_is_exception1;
    logic        dec_is_exception2;
    logic [6:0]  dec_exception_cause1;
    logic [6:0]  dec_exception_cause2;
    logic [1:0]  dec_pop;

    modport master (
        output get_data_req,
        input  fb_valid,
        input  fb_pc_out1, fb_pc_out2,
        input  fb_inst_out1, fb_inst_out2,
        input  fb_pred_taken1, fb_pred_taken2,
        input  fb_pre_branch_addr1, fb_pre_branch_addr2,
        input  fb_is_exception1, fb_is_exception2,
        input  fb_pc_exception_cause1, fb_pc_exception_cause2,
        input  fb_instbuffer_exception_cause1, fb_instbuffer_exception_cause2,
        output dec_valid,
        output dec_pc1, dec_pc2,
        output dec_inst1, dec_inst2,
        output dec_pred_taken1, dec_pred_taken2,
        output dec_pred_addr1, dec_pred_addr2,
        output dec_is_exception1, dec_is_exception2,
        output dec_exception_cause1, dec_exception_cause2,
        input  dec_pop
    );

    modport slave (
        input  get_data_req,
        output fb_valid,
        output fb_pc_out1, fb_pc_out2,
        output fb_inst_out1, fb_inst_out2,
        output fb_pred_taken1, fb_pred_taken2,
        output fb_pre_branch_addr1, fb_pre_branch_addr2,
        output fb_is_exception1, fb_is_exception2,
        output fb_pc_exception_cause1, fb_pc_exception_cause2,
        output fb_instbuffer_exception_cause1, fb_instbuffer_exception_cause2,
        input  dec_valid,
        input  dec_pc1, dec_pc2,
        input  dec_inst1, dec_inst2,
        input  dec_pred_taken1, dec_pred_taken2,
        input  dec_pred_addr1, dec_pred_addr2,
        input  dec_is_exception1, dec_is_exception2,
        input  dec_exception_cause1, dec_exception_cause2,
        output dec_pop
    );
endinterface

// File: rtl/fetch_receiver.sv
// Backend fetch receiver: pulls instruction pairs from the front-end buffer into a small
// in-order queue, merges exception causes, and offers up to two slots per cycle to decode.
module fetch_receiver #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic              flush,
    fetch_receiver_if.master  bus,
    output logic [PTR_W:0]    occupancy,
    output logic              proto_err
);

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_exc;
        logic [6:0]  cause;
    } entry_t;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   TWO_C   = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             proto_err_q, proto_err_d;

    logic             req;
    logic [1:0]       valid_out;
    logic [1:0]       num_push;
    logic [1:0]       num_pop;
    logic             push_err;
    logic             pop_err;
    logic [PTR_W-1:0] head_inc;
    logic [PTR_W-1:0] tail_inc;
    entry_t           wr0, wr1;
    entry_t           slot0, slot1;

    // Cause priority: pc-stage beats buffer-stage; 7'h7F marks "no exception".
    function automatic entry_t make_entry(
        input logic        pred_taken,
        input logic [31:0] pred_addr,
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic [1:0]  exc,
        input logic [6:0]  pc_cause,
        input logic [6:0]  buf_cause
    );
        entry_t e;
        e.pred_taken = pred_taken;
        e.pred_addr  = pred_addr;
        e.pc         = pc;
        e.inst       = inst;
        e.is_exc     = |exc;
        if (exc[1])
            e.cause = pc_cause;
        else if (exc[0])
            e.cause = buf_cause;
        else
            e.cause = 7'h7F;
        return e;
    endfunction

    // Request depends only on registered count so decode stalls never reach the front-end.
    always_comb begin
        req       = cpu_rstn && !flush && ((DEPTH_C - count_q) >= TWO_C);
        head_inc  = head_q + PTR_ONE;
        tail_inc  = tail_q + PTR_ONE;
        valid_out = 2'b00;
        if (count_q >= TWO_C)
            valid_out = 2'b11;
        else if (count_q == ONE_C)
            valid_out = 2'b01;
    end

    always_comb begin
        wr0 = make_entry(bus.fb_pred_taken1, bus.fb_pre_branch_addr1, bus.fb_pc_out1,
                         bus.fb_inst_out1, bus.fb_is_exception1,
                         bus.fb_pc_exception_cause1, bus.fb_instbuffer_exception_cause1);
        wr1 = make_entry(bus.fb_pred_taken2, bus.fb_pre_branch_addr2, bus.fb_pc_out2,
                         bus.fb_inst_out2, bus.fb_is_exception2,
                         bus.fb_pc_exception_cause2, bus.fb_instbuffer_exception_cause2);
    end

    always_comb begin
        num_push = 2'd0;
        push_err = 1'b0;
        if (req) begin
            case (bus.fb_valid)
                2'b01:   num_push = 2'd1;
                2'b11:   num_push = 2'd2;
                2'b10:   push_err = 1'b1;
                default: num_push = 2'd0;
            endcase
        end
    end

    // Any non-thermometer pop, or one asking for more slots than are valid, is dropped.
    always_comb begin
        num_pop = 2'd0;
        pop_err = 1'b0;
        case (bus.dec_pop)
            2'b00: num_pop = 2'd0;
            2'b01: begin
                if (valid_out[0]) num_pop = 2'd1;
                else              pop_err = 1'b1;
            end
            2'b11: begin
                if (valid_out[1]) num_pop = 2'd2;
                else              pop_err = 1'b1;
            end
            default: pop_err = 1'b1;
        endcase
    end

    always_comb begin
        mem_d       = mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        proto_err_d = proto_err_q | push_err | pop_err;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (num_push != 2'd0)
                mem_d[tail_q] = wr0;
            if (num_push == 2'd2)
                mem_d[tail_inc] = wr1;
            tail_d  = tail_q + PTR_W'(num_push);
            head_d  = head_q + PTR_W'(num_pop);
            count_d = count_q + (PTR_W + 1)'(num_push) - (PTR_W + 1)'(num_pop);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Queue storage carries no reset; its contents are only visible behind dec_valid.
    always_ff @(posedge cpu_clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        slot0 = valid_out[0] ? mem_q[head_q]   : '0;
        slot1 = valid_out[1] ? mem_q[head_inc] : '0;

        bus.get_data_req         = req;
        bus.dec_valid            = valid_out;
        bus.dec_pc1              = slot0.pc;
        bus.dec_pc2              = slot1.pc;
        bus.dec_inst1            = slot0.inst;
        bus.dec_inst2            = slot1.inst;
        bus.dec_pred_taken1      = slot0.pred_taken;
        bus.dec_pred_taken2      = slot1.pred_taken;
        bus.dec_pred_addr1       = slot0.pred_addr;
        bus.dec_pred_addr2       = slot1.pred_addr;
        bus.dec_is_exception1    = slot0.is_exc;
        bus.dec_is_exception2    = slot1.is_exc;
        bus.dec_exception_cause1 = slot0.cause;
        bus.dec_exception_cause2 = slot1.cause;

        occupancy = count_q;
        proto_err = proto_err_q;
    end

endmodule

// File: tb/tb_fetch_receiver.sv
// Directed bench for fetch_receiver: fill/drain, wrap-around, exception merge, flush,
// protocol errors and asynchronous reset, with hand-computed expectations.
module tb_fetch_receiver;

    logic       cpu_clk;
    logic       cpu_rstn;
    logic       flush;
    logic [2:0] occupancy;
    logic       proto_err;
    int         checks;
    int         errors;

    fetch_receiver_if bus ();

    fetch_receiver #(.DEPTH(4), .PTR_W(2)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .proto_err (proto_err)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Instruction word is ~pc and predicted target is pc+0x100 so every field is traceable.
    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pc1,
                                 input logic [31:0] pc2, input logic [1:0] pop);
        bus.fb_valid                       = valid;
        bus.fb_pc_out1                     = pc1;
        bus.fb_pc_out2                     = pc2;
        bus.fb_inst_out1                   = ~pc1;
        bus.fb_inst_out2                   = ~pc2;
        bus.fb_pred_taken1                 = 1'b1;
        bus.fb_pred_taken2                 = 1'b0;
        bus.fb_pre_branch_addr1            = pc1 + 32'h100;
        bus.fb_pre_branch_addr2            = pc2 + 32'h100;
        bus.fb_is_exception1               = 2'b00;
        bus.fb_is_exception2               = 2'b00;
        bus.fb_pc_exception_cause1         = 7'h00;
        bus.fb_pc_exception_cause2         = 7'h00;
        bus.fb_instbuffer_exception_cause1 = 7'h00;
        bus.fb_instbuffer_exception_cause2 = 7'h00;
        bus.dec_pop                        = pop;
    endtask

    task automatic stepCycle;
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cpu_rstn = 1'b0;
        flush    = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #3;
        checkOutput("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
        checkOutput("rst_proto_err", 32'(proto_err), 32'h0);
        checkOutput("rst_req", 32'(bus.get_data_req), 32'h0);

        stepCycle();
        cpu_rstn = 1'b1;
        applyStimulus(2'b11, 32'h1c000000, 32'h1c000004, 2'b00);
        #1;
        checkOutput("first_req", 32'(bus.get_data_req), 32'h1);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("first_dec_valid", 32'(bus.dec_valid), 32'h3);
        checkOutput("first_pc1", bus.dec_pc1, 32'h1c000000);
        checkOutput("first_pc2", bus.dec_pc2, 32'h1c000004);
        checkOutput("first_inst1", bus.dec_inst1, 32'he3ffffff);
        checkOutput("first_pred_taken1", 32'(bus.dec_pred_taken1), 32'h1);
        checkOutput("first_pred_taken2", 32'(bus.dec_pred_taken2), 32'h0);
        checkOutput("first_pred_addr1", bus.dec_pred_addr1, 32'h1c000100);
        checkOutput("first_occupancy", 32'(occupancy), 32'h2);

        applyStimulus(2'b11, 32'h1c000008, 32'h1c00000c, 2'b00);
        #1;
        checkOutput("fill_req_before", 32'(bus.get_data_req), 32'h1);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("full_occupancy", 32'(occupancy), 32'h4);
        checkOutput("full_req", 32'(bus.get_data_req), 32'h0);

        applyStimulus(2'b11, 32'hdead0000, 32'hdead0004, 2'b00);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("full_ignore_occ", 32'(occupancy), 32'h4);
        checkOutput("full_ignore_err", 32'(proto_err), 32'h0);
        checkOutput("full_ignore_pc1", bus.dec_pc1, 32'h1c000000);

        applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("pop2_occupancy", 32'(occupancy), 32'h2);
        checkOutput("pop2_req", 32'(bus.get_data_req), 32'h1);
        checkOutput("pop2_pc1", bus.dec_pc1, 32'h1c000008);
        checkOutput("pop2_pc2", bus.dec_pc2, 32'h1c00000c);

        applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("drain_occupancy", 32'(occupancy), 32'h0);
        checkOutput("drain_dec_valid", 32'(bus.dec_valid), 32'h0);

        applyStimulus(2'b01, 32'h20000000, 32'h0, 2'b00);
        stepCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b01, 32'h20000000 + 32'(4 * (i + 1)), 32'h0, 2'b01);
            #1;
            checkOutput("wrap_dec_valid", 32'(bus.dec_valid), 32'h1);
            checkOutput("wrap_pc1", bus.dec_pc1, 32'h20000000 + 32'(4 * i));
            stepCycle();
            checkOutput("wrap_occupancy", 32'(occupancy), 32'h1);
        end
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b01);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("wrap_end_occ", 32'(occupancy), 32'h0);

        applyStimulus(2'b11, 32'h30000000, 32'h30000004, 2'b00);
        bus.fb_is_exception1               = 2'b11;
        bus.fb_pc_exception_cause1         = 7'h08;
        bus.fb_instbuffer_exception_cause1 = 7'h0D;
        bus.fb_is_exception2               = 2'b01;
        bus.fb_pc_exception_cause2         = 7'h08;
        bus.fb_instbuffer_exception_cause2 = 7'h0D;
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("exc11_cause1", 32'(bus.dec_exception_cause1), 32'h08);
        checkOutput("exc11_is_exc1", 32'(bus.dec_is_exception1), 32'h1);
        checkOutput("exc01_cause2", 32'(bus.dec_exception_cause2), 32'h0D);
        checkOutput("exc01_is_exc2", 32'(bus.dec_is_exception2), 32'h1);

        applyStimulus(2'b01, 32'h30000008, 32'h0, 2'b11);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("exc00_occupancy", 32'(occupancy), 32'h1);
        checkOutput("exc00_dec_valid", 32'(bus.dec_valid), 32'h1);
        checkOutput("exc00_pc1", bus.dec_pc1, 32'h30000008);
        checkOutput("exc00_cause1", 32'(bus.dec_exception_cause1), 32'h7F);
        checkOutput("exc00_is_exc1", 32'(bus.dec_is_exception1), 32'h0);

        applyStimulus(2'b11, 32'h40000000, 32'h40000004, 2'b00);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("preflush_occ", 32'(occupancy), 32'h3);
        flush = 1'b1;
        applyStimulus(2'b11, 32'h50000000, 32'h50000004, 2'b01);
        #1;
        checkOutput("flush_req", 32'(bus.get_data_req), 32'h0);
        stepCycle();
        flush = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("flush_occupancy", 32'(occupancy), 32'h0);
        checkOutput("flush_dec_valid", 32'(bus.dec_valid), 32'h0);
        checkOutput("flush_req_after", 32'(bus.get_data_req), 32'h1);
        checkOutput("flush_proto_err", 32'(proto_err), 32'h0);

        applyStimulus(2'b01, 32'h60000000, 32'h0, 2'b00);
        stepCycle();
        applyStimulus(2'b10, 32'h70000000, 32'h70000004, 2'b00);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("badvalid_occ", 32'(occupancy), 32'h1);
        checkOutput("badvalid_err", 32'(proto_err), 32'h1);
        checkOutput("badvalid_pc1", bus.dec_pc1, 32'h60000000);

        #2;
        cpu_rstn = 1'b0;
        #1;
        checkOutput("async_rst_occ", 32'(occupancy), 32'h0);
        checkOutput("async_rst_err", 32'(proto_err), 32'h0);
        checkOutput("async_rst_valid", 32'(bus.dec_valid), 32'h0);
        stepCycle();
        cpu_rstn = 1'b1;

        applyStimulus(2'b01, 32'h60000010, 32'h0, 2'b00);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b11);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        #1;
        checkOutput("overpop_occ", 32'(occupancy), 32'h1);
        checkOutput("overpop_err", 32'(proto_err), 32'h1);
        checkOutput("overpop_valid", 32'(bus.dec_valid), 32'h1);

        applyStimulus(2'b00, 32'h0, 32'h0, 2'b10);
        stepCycle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
        repeat (3) stepCycle();
        checkOutput("badpop_occ", 32'(occupancy), 32'h1);
        checkOutput("sticky_err", 32'(proto_err), 32'h1);
        checkOutput("sticky_pc1", bus.dec_pc1, 32'h60000010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
